// File: rtl/seqdet_pkg.sv
// Shared helpers for the serial pattern detector: state width and KMP next-state rule.
// Latency: none (elaboration-time constant functions only).
// Backpressure: none.
package seqdet_pkg;

    localparam int         DEF_LEN     = 4;
    localparam logic [3:0] DEF_PATTERN = 4'b1011;

    function automatic int state_w(input int len);
        return (len < 1) ? 1 : $clog2(len + 1);
    endfunction

    // Pattern bit i in arrival order lives at pattern[len-1-i].
    // The candidate string is the first k pattern bits followed by b; the result
    // is the longest pattern prefix (capped at len) that is a suffix of it.
    function automatic int next_state(input int k, input logic b,
                                      input logic [15:0] pattern,
                                      input int len, input bit overlap);
        int   best;
        int   pos;
        logic match;
        logic sb;
        best = 0;
        if (k < 0 || k > len) begin
            best = 0;
        end else if (k == len && !overlap) begin
            best = (b == pattern[len-1]) ? 1 : 0;
        end else begin
            for (int j = 1; j <= len; j++) begin
                if (j <= k + 1) begin
                    match = 1'b1;
                    for (int t = 0; t < j; t++) begin
                        pos = k + 1 - j + t;
                        sb  = (pos < k) ? pattern[len-1-pos] : b;
                        if (sb != pattern[len-1-t]) match = 1'b0;
                    end
                    if (match) best = j;
                end
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/sequence_detector.sv
// Serial sync-word detector: y flags when the last LEN bits of x equal PATTERN.
// Latency: y rises on the edge that samples the final pattern bit (registered, no x->y path).
// Backpressure: none; one bit consumed every clock.
module sequence_detector
    import seqdet_pkg::*;
#(
    parameter int             LEN     = DEF_LEN,
    parameter logic [LEN-1:0] PATTERN = DEF_PATTERN,
    parameter bit             OVERLAP = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic x,
    output logic y
);

    localparam int          SW    = state_w(LEN);
    localparam int          NS    = 1 << SW;
    localparam logic [15:0] PAT16 = 16'(PATTERN);

    typedef logic [SW-1:0] state_t;

    localparam state_t S_FULL = state_t'(LEN);

    state_t state;
    state_t nxt;
    state_t tbl0 [NS];
    state_t tbl1 [NS];

    // Unused encodings above S_FULL come out of next_state as 0, so they recover to S0.
    for (genvar k = 0; k < NS; k++) begin : g_tbl
        localparam int N0 = next_state(k, 1'b0, PAT16, LEN, OVERLAP);
        localparam int N1 = next_state(k, 1'b1, PAT16, LEN, OVERLAP);
        assign tbl0[k] = state_t'(N0);
        assign tbl1[k] = state_t'(N1);
    end

    always_comb begin
        nxt = x ? tbl1[state] : tbl0[state];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= '0;
            y     <= 1'b0;
        end else begin
            state <= nxt;
            y     <= (nxt == S_FULL);
        end
    end

endmodule

// File: tb/tb_sequence_detector.sv
// Directed bench for sequence_detector: default 1011 overlap, 1011 non-overlap, and LEN=3 pattern 111.
module tb_sequence_detector;

    logic clk;
    logic reset;
    logic x;
    logic y_def;
    logic y_nov;
    logic y_l3;

    int checks;
    int errors;

    sequence_detector dut_def (
        .clk   (clk),
        .reset (reset),
        .x     (x),
        .y     (y_def)
    );

    sequence_detector #(.OVERLAP(1'b0)) dut_nov (
        .clk   (clk),
        .reset (reset),
        .x     (x),
        .y     (y_nov)
    );

    sequence_detector #(.LEN(3), .PATTERN(3'b111)) dut_l3 (
        .clk   (clk),
        .reset (reset),
        .x     (x),
        .y     (y_l3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one bit, clock it, then settle past the edge before sampling.
    task automatic step(input logic b);
        @(negedge clk);
        x = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        x     = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (y_def !== 1'b0) begin
            errors++;
            $display("FAIL reset_y_def: got %b want 0", y_def);
        end
        checks++;
        if (y_nov !== 1'b0) begin
            errors++;
            $display("FAIL reset_y_nov: got %b want 0", y_nov);
        end
        checks++;
        if (y_l3 !== 1'b0) begin
            errors++;
            $display("FAIL reset_y_l3: got %b want 0", y_l3);
        end
    endtask

    task automatic test_basic();
        logic [4:0] s;
        logic [4:0] e;
        s = 5'b10110;
        e = 5'b00010;
        do_reset();
        for (int i = 4; i >= 0; i--) begin
            step(s[i]);
            checks++;
            if (y_def !== e[i]) begin
                errors++;
                $display("FAIL basic bit%0d: got %b want %b", 5 - i, y_def, e[i]);
            end
        end
    endtask

    task automatic test_overlap();
        logic [6:0] s;
        logic [6:0] e_ov;
        logic [6:0] e_no;
        s    = 7'b1011011;
        e_ov = 7'b0001001;
        e_no = 7'b0001000;
        do_reset();
        for (int i = 6; i >= 0; i--) begin
            step(s[i]);
            checks++;
            if (y_def !== e_ov[i]) begin
                errors++;
                $display("FAIL overlap bit%0d: got %b want %b", 7 - i, y_def, e_ov[i]);
            end
            checks++;
            if (y_nov !== e_no[i]) begin
                errors++;
                $display("FAIL no_overlap bit%0d: got %b want %b", 7 - i, y_nov, e_no[i]);
            end
        end
    endtask

    task automatic test_near_miss();
        logic [5:0] s;
        logic [5:0] e;
        s = 6'b101011;
        e = 6'b000001;
        do_reset();
        for (int i = 5; i >= 0; i--) begin
            step(s[i]);
            checks++;
            if (y_def !== e[i]) begin
                errors++;
                $display("FAIL near_miss bit%0d: got %b want %b", 6 - i, y_def, e[i]);
            end
        end
    endtask

    task automatic test_ones_run();
        logic [5:0] s;
        logic [5:0] e;
        s = 6'b111011;
        e = 6'b000001;
        do_reset();
        for (int i = 5; i >= 0; i--) begin
            step(s[i]);
            checks++;
            if (y_def !== e[i]) begin
                errors++;
                $display("FAIL ones_run bit%0d: got %b want %b", 6 - i, y_def, e[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [3:0] s;
        logic [3:0] e;
        do_reset();
        step(1'b1);
        step(1'b0);
        step(1'b1);
        // Final pattern bit arrives together with reset: no detection allowed.
        @(negedge clk);
        reset = 1'b1;
        x     = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (y_def !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_y: got %b want 0", y_def);
        end
        @(negedge clk);
        reset = 1'b0;
        s = 4'b1011;
        e = 4'b0001;
        for (int i = 3; i >= 0; i--) begin
            step(s[i]);
            checks++;
            if (y_def !== e[i]) begin
                errors++;
                $display("FAIL after_reset bit%0d: got %b want %b", 4 - i, y_def, e[i]);
            end
        end
    endtask

    task automatic test_len3();
        logic [4:0] e;
        e = 5'b00111;
        do_reset();
        for (int i = 4; i >= 0; i--) begin
            step(1'b1);
            checks++;
            if (y_l3 !== e[i]) begin
                errors++;
                $display("FAIL len3_ones bit%0d: got %b want %b", 5 - i, y_l3, e[i]);
            end
        end
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b0);
            checks++;
            if (y_l3 !== 1'b0) begin
                errors++;
                $display("FAIL len3_zeros bit%0d: got %b want 0", i + 1, y_l3);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        x      = 1'b0;
        test_reset();
        test_basic();
        test_overlap();
        test_near_miss();
        test_ones_run();
        test_mid_reset();
        test_len3();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sequence_detector.md
Name: sequence_detector

Overview:
- Serial bit-pattern detector: samples one input bit `x` per rising clock edge and asserts `y` when the most recent LEN bits equal PATTERN.
- Default configuration detects "1011" (MSB = first bit received), with overlap allowed.
- Moore-style registered output.
- Sits on a serial input stream as a lightweight framing/sync-word flag generator.

Parameters:
- LEN, 4: pattern length in bits; legal range 1..16.
- PATTERN, 4'b1011: target sequence. Bit [LEN-1] is the first bit received, bit [0] the last.
- OVERLAP, 1: 1 = a match's suffix may begin the next match; 0 = after a match, the search restarts from the empty state.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- x  input  1  serial data bit, sampled on every rising clk edge.
- y  output  1  detect flag; high for exactly the cycle(s) in which the state equals "full match".

Behaviour:
- Clocking and reset:
  - One clock (clk).
  - Reset is synchronous and active-high: reset sampled high at a rising edge forces state to S0 and y to 0.
  - x is ignored on any edge where reset is high.
  - Reset asserted mid-sequence discards all partial progress.
- States:
  - S0..S(LEN), where Sk means "the last k bits received equal the first k bits of PATTERN, and k is the longest such prefix".
  - Encoding: binary, width clog2(LEN+1).
- Transitions from Sk on input bit b:
  - If k<LEN and b equals the next pattern bit, go to S(k+1).
  - Otherwise go to the longest prefix of PATTERN that is a suffix of (matched prefix + b). This is the KMP failure rule.
  - Compute the transition table at elaboration with a constant function. No runtime table.
  - From S(LEN): if OVERLAP=1, apply the same failure rule; if OVERLAP=0, go to S1 when b equals PATTERN[LEN-1], else S0.
- Default table, PATTERN=1011, OVERLAP=1 (next state for x=0 / x=1):
  - S0: S0 / S1
  - S1: S2 / S1
  - S2: S0 / S3
  - S3: S2 / S4
  - S4: S2 / S1
- Output:
  - y = (state == S(LEN)), decoded from the state register. No combinational path from x to y.
  - Latency: y rises on the same edge that samples the final pattern bit, and is valid until the next edge.
  - Consecutive overlapping matches produce y high in each matching cycle. Example: "1011011" gives y pulses after bit 4 and after bit 7.
- Invalid state encodings (LEN+1 up to 2^width-1) recover to S0 on the next edge.
- Power-up before the first reset: undefined; the bench must apply reset first.

Decomposition:
- Package `seqdet_pkg`:
  - state width function, clog2(LEN+1);
  - constant function next_state(k, b, PATTERN, LEN, OVERLAP);
  - default constants DEF_LEN=4, DEF_PATTERN=4'b1011.
- Single module. No sub-module is needed; the table generator is a package function, not a separate block.

Test Plan:
- Reset high for one edge with x=0, then release; stream x=1,0,1,1 on successive edges -> y=0 for the first three edges, y=1 after the 4th edge, y=0 again after the next edge (x=0).
- Overlap stream 1,0,1,1,0,1,1 -> y high after bit 4 and after bit 7. With OVERLAP=0 the same stream -> y high after bit 4 only.
- Near-miss stream 1,0,1,0,1,1 -> no y on the 4th bit; the S3→S2 fallback yields y=1 after bit 6.
- Stream 1,1,1,0,1,1 -> y=1 after bit 6 only; the run of ones holds the FSM in S1.
- Reset asserted on the edge where the 4th bit (1) of 1011 is presented -> y stays 0, state=S0; a subsequent 1011 is detected normally.
- Parameter sweep with LEN=3, PATTERN=3'b111 on stream 1,1,1,1,1 -> y high after bits 3, 4 and 5; all-zero stream -> y never asserts.
